serial_rx: RTL
==============

SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 100, clocks per serial bit (100 MHz / 1 Mbaud); legal range 8..65535.
REQ-002 SHALL have port clk  input  1  system clock, 100 MHz, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port data  output  8  last correctly received byte.
REQ-006 SHALL have port new_data  output  1  one-cycle strobe, data updated this cycle.
REQ-007 SHALL have port frame_err  output  1  one-cycle strobe, stop bit sampled low.
REQ-008 SHALL have port busy  output  1  high while any state other than IDLE is active.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value rxs.
REQ-010 SHALL use frame format 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
REQ-011 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-012 IDLE: on rxs==0 -> START, bit-timer cleared.
REQ-013 START: after CLKS_PER_BIT/2 clocks (integer division) sample rxs; 0 -> DATA with timer cleared, bit index 0; 1 -> IDLE, no strobe (glitch rejection).
REQ-014 DATA: every CLKS_PER_BIT clocks sample rxs into shift register bit[index]; after index 7 -> STOP.
REQ-015 STOP: after CLKS_PER_BIT clocks sample rxs; 1 -> data<=shift, new_data=1 next cycle, -> IDLE; 0 -> frame_err=1 next cycle, data unchanged, -> WAIT_HIGH.
REQ-016 WAIT_HIGH: remain until rxs==1, then -> IDLE; a held-low line (break) SHALL produce exactly one frame_err.
REQ-017 new_data and frame_err SHALL never be high simultaneously and SHALL each be high for exactly one clock per frame.
REQ-018 data SHALL change only in the cycle new_data is high; otherwise hold.
REQ-019 Latency: new_data SHALL rise between 9.5*CLKS_PER_BIT+2 and 9.5*CLKS_PER_BIT+5 clocks after rx falls.
REQ-020 Bit timer width SHALL be ceil(log2(CLKS_PER_BIT)) bits; timer SHALL never wrap within a bit period.
REQ-021 A new start edge arriving immediately after stop-bit sample SHALL be accepted (back-to-back frames, no idle gap required beyond the remaining half stop bit).
REQ-022 busy SHALL be high from the cycle after leaving IDLE until the cycle IDLE is re-entered.

Reset
REQ-023 On rst high, immediately (asynchronously): state=IDLE, data=8'h00, new_data=0, frame_err=0, busy=0, synchronizer flops=1, timer and index=0.
REQ-024 Reset asserted mid-frame SHALL abandon the frame with no strobe; after release, reception SHALL resume on the next falling edge.
REQ-025 If rx is low when rst releases, the block SHALL NOT start a frame until rx has been seen high then low.

Verification (CLKS_PER_BIT=100)
REQ-026 Send 0xA5 at 100 clocks/bit -> data=0xA5, new_data high exactly one cycle, frame_err never high, busy low afterwards.
REQ-027 Back-to-back 0x00 then 0xFF, no idle gap -> two new_data strobes, data=0x00 then 0xFF, ~1000 clocks apart.
REQ-028 rx low pulse of 20 clocks -> no new_data, no frame_err, busy high ~50 clocks then low.
REQ-029 Frame 0x3C with stop bit 0, line held low 500 clocks, then 0x5A -> one frame_err, data stays at previous value, then data=0x5A with new_data.
REQ-030 rst pulse during data bit 4 of 0x81, then full 0x42 -> all outputs 0 during reset, no strobe for 0x81, data=0x42 with new_data.
REQ-031 Bit rate +/-3% from nominal (97 and 103 clocks/bit), byte 0x55 -> data=0x55 received correctly both cases.

Source files
------------

// File: rtl/serial_rx.sv
// 8N1 UART receiver with mid-bit sampling, start-glitch rejection and break handling.
// data/new_data/frame_err are registered; busy is decoded from the FSM state.
module serial_rx #(
  parameter int CLKS_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       new_data,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t          state, state_nxt;
  logic            rx_meta, rxs;
  logic [1:0]      sync_vld;
  logic            armed;
  logic [TW-1:0]   timer;
  logic [2:0]      idx;
  logic [7:0]      shift;
  logic            half_done, bit_done;
  logic            timer_clr, take_bit, good_stop, bad_stop;

  assign half_done = (timer == HALF_LAST);
  assign bit_done  = (timer == BIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // The synchronizer resets high, so only trust a high level once real line
  // samples have reached rxs; a line held low through reset stays ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_vld <= 2'b00;
      armed    <= 1'b0;
    end else begin
      sync_vld <= {sync_vld[0], 1'b1};
      armed    <= armed | (sync_vld[1] & rxs);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (armed && !rxs) state_nxt = START;
      START:     if (half_done) state_nxt = rxs ? IDLE : DATA;
      DATA:      if (bit_done && idx == 3'd7) state_nxt = STOP;
      STOP:      if (bit_done) state_nxt = rxs ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rxs) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    timer_clr = 1'b1;
    take_bit  = 1'b0;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    case (state)
      START: timer_clr = half_done;
      DATA: begin
        timer_clr = bit_done;
        take_bit  = bit_done;
      end
      STOP: begin
        timer_clr = bit_done;
        good_stop = bit_done & rxs;
        bad_stop  = bit_done & ~rxs;
      end
      default: timer_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer     <= '0;
      idx       <= 3'd0;
      shift     <= 8'h00;
      data      <= 8'h00;
      new_data  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      timer     <= timer_clr ? '0 : timer + 1'b1;
      new_data  <= good_stop;
      frame_err <= bad_stop;
      if (state != DATA)  idx <= 3'd0;
      else if (bit_done)  idx <= idx + 3'd1;
      if (take_bit)  shift[idx] <= rxs;
      if (good_stop) data <= shift;
    end
  end

endmodule
